blm_pulse_counter: RTL and testbench

//  Consumer of the deglitcher output in the BLM channel: counts rising edges of the

---
 rtl/blm_pulse_counter.sv | 130 +++++++++++++
 tb/tb_blm_pulse_counter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blm_pulse_counter.sv
// BLM loss-pulse counter: counts deglitched rising edges per gate window.
// Define BLM_CNT_SAT_EN for a saturating counter with an overflow flag.
module blm_pulse_counter #(
   parameter int CNT_WIDTH = 16,
   parameter int WIN_WIDTH = 24
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cnt_in,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [WIN_WIDTH-1:0] win_len,
   input  logic [CNT_WIDTH-1:0] thresh,
   output logic [CNT_WIDTH-1:0] cnt_live,
   output logic [CNT_WIDTH-1:0] cnt_last,
   output logic                 cnt_valid,
   output logic                 over_thresh,
   output logic                 overflow
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 prev_in;
   logic                 pulse_edge;
   logic [WIN_WIDTH-1:0] win_cnt;
   logic [WIN_WIDTH-1:0] win_cnt_nxt;
   logic [WIN_WIDTH-1:0] win_load;
   logic [CNT_WIDTH-1:0] sum;
   logic [CNT_WIDTH-1:0] live_nxt;
   logic [CNT_WIDTH-1:0] last_nxt;
   logic                 over_nxt;
   logic                 valid_nxt;

   assign pulse_edge = cnt_in & ~prev_in;

   // a zero-length window behaves as a one-cycle window
   assign win_load = (win_len == '0) ? '0
                   : win_len - WIN_WIDTH'(1);

`ifdef BLM_CNT_SAT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   assign sum = (cnt_live == CNT_MAX) ? CNT_MAX
              : cnt_live + CNT_WIDTH'(pulse_edge);
`else
   assign sum = cnt_live + CNT_WIDTH'(pulse_edge);
`endif

   always_comb begin
      state_nxt   = state;
      win_cnt_nxt = win_cnt;
      live_nxt    = cnt_live;
      last_nxt    = cnt_last;
      over_nxt    = over_thresh;
      valid_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear) begin
               live_nxt    = '0;
               win_cnt_nxt = win_load;
            end else if (enable) begin
               state_nxt   = RUN;
               live_nxt    = '0;
               win_cnt_nxt = win_load;
            end
         end
         RUN: begin
            if (!enable) begin
               state_nxt = IDLE;
               live_nxt  = '0;
            end else if (clear) begin
               live_nxt    = '0;
               win_cnt_nxt = win_load;
            end else if (win_cnt == '0) begin
               last_nxt    = sum;
               over_nxt    = (sum >= thresh);
               valid_nxt   = 1'b1;
               live_nxt    = '0;
               win_cnt_nxt = win_load;
            end else begin
               live_nxt    = sum;
               win_cnt_nxt = win_cnt - WIN_WIDTH'(1);
            end
         end
      endcase
   end

   // prev_in resets high so a level already present at release is not an edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         prev_in     <= 1'b1;
         win_cnt     <= '0;
         cnt_live    <= '0;
         cnt_last    <= '0;
         cnt_valid   <= 1'b0;
         over_thresh <= 1'b0;
      end else begin
         state       <= state_nxt;
         prev_in     <= cnt_in;
         win_cnt     <= win_cnt_nxt;
         cnt_live    <= live_nxt;
         cnt_last    <= last_nxt;
         cnt_valid   <= valid_nxt;
         over_thresh <= over_nxt;
      end
   end

`ifdef BLM_CNT_SAT_EN
   logic ovf_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (valid_nxt) begin
         ovf_q <= (sum == CNT_MAX);
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_blm_pulse_counter.sv
// Bench for blm_pulse_counter: directed scenarios plus random traffic
// against an unbounded-count window model, on 16-bit and 4-bit instances.
module tb_blm_pulse_counter;

   localparam int CW = 16;
   localparam int SW = 4;
   localparam int WW = 24;
`ifdef BLM_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cnt_in = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic [WW-1:0] win_len = '0;
   logic [CW-1:0] thresh = '0;
   logic [CW-1:0] cnt_live;
   logic [CW-1:0] cnt_last;
   logic          cnt_valid;
   logic          over_thresh;
   logic          overflow;
   logic [SW-1:0] s_live;
   logic [SW-1:0] s_last;
   logic          s_valid;
   logic          s_over;
   logic          s_ovf;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   blm_pulse_counter #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
      .clock(clock), .reset(reset), .cnt_in(cnt_in),
      .enable(enable), .clear(clear), .win_len(win_len),
      .thresh(thresh), .cnt_live(cnt_live), .cnt_last(cnt_last),
      .cnt_valid(cnt_valid), .over_thresh(over_thresh),
      .overflow(overflow)
   );

   blm_pulse_counter #(.CNT_WIDTH(SW), .WIN_WIDTH(WW)) dut4 (
      .clock(clock), .reset(reset), .cnt_in(cnt_in),
      .enable(enable), .clear(clear), .win_len(win_len),
      .thresh(thresh[SW-1:0]), .cnt_live(s_live),
      .cnt_last(s_last), .cnt_valid(s_valid),
      .over_thresh(s_over), .overflow(s_ovf)
   );

   // model: window bookkeeping with an unbounded edge count
   bit m_run, m_prev, m_valid;
   int m_rem, m_count;
   int m_last16, m_last4;
   bit m_over16, m_over4, m_ovf16, m_ovf4;

   function automatic int fold(int c, int w);
      int mx;
      mx = (1 << w) - 1;
      if (SAT) return (c > mx) ? mx : c;
      return c % (1 << w);
   endfunction

   function automatic int wlen(int wl);
      return (wl == 0) ? 1 : wl;
   endfunction

   task automatic model_reset();
      m_run = 0; m_prev = 1; m_valid = 0;
      m_rem = 0; m_count = 0;
      m_last16 = 0; m_last4 = 0;
      m_over16 = 0; m_over4 = 0;
      m_ovf16 = 0; m_ovf4 = 0;
   endtask

   task automatic model_step(input bit i, input bit en,
                             input bit clr, input int wl,
                             input int th);
      bit e;
      e = i && !m_prev;
      m_prev = i;
      m_valid = 0;
      if (!m_run) begin
         if (clr) m_count = 0;
         else if (en) begin
            m_run = 1; m_rem = wlen(wl); m_count = 0;
         end
      end else if (!en) begin
         m_run = 0; m_count = 0;
      end else if (clr) begin
         m_count = 0; m_rem = wlen(wl);
      end else begin
         m_count += int'(e);
         m_rem--;
         if (m_rem == 0) begin
            m_valid = 1;
            m_last16 = fold(m_count, CW);
            m_last4 = fold(m_count, SW);
            m_over16 = m_last16 >= th;
            m_over4 = m_last4 >= (th & 15);
            m_ovf16 = SAT && m_count >= 65535;
            m_ovf4 = SAT && m_count >= 15;
            m_count = 0;
            m_rem = wlen(wl);
         end
      end
   endtask

   task automatic cyc(input bit i, input bit en, input bit clr);
      int wl, th;
      cnt_in = i; enable = en; clear = clr;
      wl = int'(win_len); th = int'(thresh);
      @(posedge clock);
      model_step(i, en, clr, wl, th);
      #1;
   endtask

   task automatic do_reset(input bit held);
      reset = 1; cnt_in = held; enable = 0; clear = 0;
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset = 0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (cnt_live !== 0 || cnt_last !== 0 || cnt_valid !== 0
          || over_thresh !== 0 || overflow !== 0) begin
         bad++;
         $display("FAIL reset_state live=%0d last=%0d v=%b o=%b f=%b want 0",
                  cnt_live, cnt_last, cnt_valid, over_thresh, overflow);
      end
      do_reset(0);
      win_len = 20; thresh = 0;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0);
      total++;
      if (cnt_live !== CW'(m_count)) begin
         bad++;
         $display("FAIL pre_reset_live got=%0d want=%0d",
                  cnt_live, m_count);
      end
      #2 reset = 1;
      model_reset();
      #1;
      total++;
      if (cnt_live !== 0 || cnt_last !== 0 || cnt_valid !== 0
          || s_live !== 0) begin
         bad++;
         $display("FAIL mid_reset live=%0d last=%0d v=%b want 0",
                  cnt_live, cnt_last, cnt_valid);
      end
      @(negedge clock);
      reset = 0;
   endtask

   task automatic test_basic();
      bit p[10] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      int nv;
      do_reset(0);
      win_len = 10; thresh = 3;
      cyc(0, 1, 0);
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(p[i], 1, 0);
         if (cnt_valid) nv++;
      end
      total++;
      if (nv !== 1 || cnt_valid !== 1) begin
         bad++;
         $display("FAIL basic_strobe count=%0d last_v=%b want 1/1",
                  nv, cnt_valid);
      end
      total++;
      if (cnt_last !== 16'd3 || over_thresh !== 1) begin
         bad++;
         $display("FAIL basic_count got=%0d/%b want 3/1",
                  cnt_last, over_thresh);
      end
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 1, 0);
         if (cnt_valid) nv++;
      end
      total++;
      if (nv !== 1 || cnt_last !== 0 || over_thresh !== 0) begin
         bad++;
         $display("FAIL basic_empty n=%0d last=%0d o=%b want 1/0/0",
                  nv, cnt_last, over_thresh);
      end
   endtask

   task automatic test_held_high();
      do_reset(1);
      win_len = 4; thresh = 1;
      cyc(1, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0);
      total++;
      if (cnt_valid !== 1 || cnt_last !== 0 || over_thresh !== 0) begin
         bad++;
         $display("FAIL held_high v=%b last=%0d o=%b want 1/0/0",
                  cnt_valid, cnt_last, over_thresh);
      end
   endtask

   task automatic test_last_edge();
      do_reset(0);
      win_len = 5; thresh = 1;
      cyc(0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0);
      cyc(1, 1, 0);
      total++;
      if (cnt_valid !== 1 || cnt_last !== 1 || cnt_live !== 0) begin
         bad++;
         $display("FAIL last_edge v=%b last=%0d live=%0d want 1/1/0",
                  cnt_valid, cnt_last, cnt_live);
      end
      cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0);
      total++;
      if (cnt_live !== 1 || cnt_live !== CW'(m_count)) begin
         bad++;
         $display("FAIL next_window_live got=%0d want 1", cnt_live);
      end
   endtask

   task automatic test_disable_clear();
      int nv, n;
      bit got;
      do_reset(0);
      win_len = 3; thresh = 1;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
      total++;
      if (cnt_last !== 1 || cnt_valid !== 1) begin
         bad++;
         $display("FAIL pre_publish last=%0d v=%b want 1/1",
                  cnt_last, cnt_valid);
      end
      cyc(0, 0, 0);
      win_len = 8;
      cyc(0, 1, 0); cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0);
      total++;
      if (cnt_live !== 2) begin
         bad++;
         $display("FAIL live_before_drop got=%0d want 2", cnt_live);
      end
      cyc(0, 0, 0);
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(i[0], 0, 0);
         if (cnt_valid) nv++;
      end
      total++;
      if (nv !== 0 || cnt_last !== 1 || cnt_live !== 0) begin
         bad++;
         $display("FAIL disable n=%0d last=%0d live=%0d want 0/1/0",
                  nv, cnt_last, cnt_live);
      end
      cyc(0, 1, 0);
      cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(0, 1, 0);
      cyc(0, 1, 1);
      total++;
      if (cnt_live !== 0 || cnt_valid !== 0) begin
         bad++;
         $display("FAIL clear_live live=%0d v=%b want 0/0",
                  cnt_live, cnt_valid);
      end
      n = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc(0, 1, 0);
         n++;
         got = cnt_valid;
      end
      total++;
      if (!got || n !== 8 || cnt_last !== 0) begin
         bad++;
         $display("FAIL clear_restart len=%0d last=%0d want 8/0",
                  n, cnt_last);
      end
   endtask

   task automatic test_zero_len();
      int nv, n;
      bit got;
      do_reset(0);
      win_len = 0; thresh = 1;
      cyc(0, 1, 0);
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(!i[0], 1, 0);
         if (cnt_valid) nv++;
         total++;
         if (cnt_last !== CW'(m_last16)) begin
            bad++;
            $display("FAIL zero_len_last got=%0d want=%0d",
                     cnt_last, m_last16);
         end
      end
      total++;
      if (nv !== 8) begin
         bad++;
         $display("FAIL zero_len_strobes got=%0d want 8", nv);
      end
      do_reset(0);
      win_len = 4;
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      win_len = 6;
      n = 1; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc(0, 1, 0);
         n++;
         got = cnt_valid;
      end
      total++;
      if (!got || n !== 4) begin
         bad++;
         $display("FAIL len_change_cur got=%0d want 4", n);
      end
      n = 0; got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc(0, 1, 0);
         n++;
         got = cnt_valid;
      end
      total++;
      if (!got || n !== 6) begin
         bad++;
         $display("FAIL len_change_next got=%0d want 6", n);
      end
   endtask

   task automatic test_saturate();
      logic [SW-1:0] want;
      do_reset(0);
      win_len = 40; thresh = 0;
      cyc(0, 1, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0);
         cyc(0, 1, 0);
      end
      want = SAT ? 4'd15 : 4'd4;
      total++;
      if (s_valid !== 1 || s_last !== want || s_ovf !== SAT) begin
         bad++;
         $display("FAIL sat4 v=%b last=%0d ovf=%b want 1/%0d/%b",
                  s_valid, s_last, s_ovf, want, SAT);
      end
      total++;
      if (cnt_last !== 20 || overflow !== 0) begin
         bad++;
         $display("FAIL sat16 last=%0d ovf=%b want 20/0",
                  cnt_last, overflow);
      end
   endtask

   task automatic test_random();
      bit i, en, clr;
      do_reset(0);
      win_len = 3; thresh = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) win_len = WW'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) thresh = CW'($urandom_range(0, 6));
         i = ($urandom_range(0, 9) < 4);
         en = ($urandom_range(0, 39) != 0);
         clr = ($urandom_range(0, 49) == 0);
         cyc(i, en, clr);
         total++;
         if (cnt_live !== CW'(fold(m_count, CW))
             || s_live !== SW'(fold(m_count, SW))) begin
            bad++;
            $display("FAIL rnd_live c=%0d got=%0d/%0d want=%0d",
                     c, cnt_live, s_live, m_count);
         end
         total++;
         if (cnt_valid !== m_valid || s_valid !== m_valid) begin
            bad++;
            $display("FAIL rnd_valid c=%0d got=%b/%b want=%b",
                     c, cnt_valid, s_valid, m_valid);
         end
         total++;
         if (cnt_last !== CW'(m_last16) || s_last !== SW'(m_last4)) begin
            bad++;
            $display("FAIL rnd_last c=%0d got=%0d/%0d want=%0d/%0d",
                     c, cnt_last, s_last, m_last16, m_last4);
         end
         total++;
         if (over_thresh !== m_over16 || s_over !== m_over4) begin
            bad++;
            $display("FAIL rnd_over c=%0d got=%b/%b want=%b/%b",
                     c, over_thresh, s_over, m_over16, m_over4);
         end
         total++;
         if (overflow !== m_ovf16 || s_ovf !== m_ovf4) begin
            bad++;
            $display("FAIL rnd_ovf c=%0d got=%b/%b want=%b/%b",
                     c, overflow, s_ovf, m_ovf16, m_ovf4);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_held_high();
      test_last_edge();
      test_disable_clear();
      test_zero_len();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
